// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounced two-button run/set sequencer for the time-of-day counter.
// Emits a one-cycle load strobe with the edited hh:mm, the counter enable and a blink mask.
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000,
  parameter int unsigned BLINK_CYCLES    = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode_n_i,
  input  logic       btn_inc_n_i,
  input  logic [5:0] cur_hours_i,
  input  logic [5:0] cur_minutes_i,
  output logic [5:0] set_hours_o,
  output logic [5:0] set_minutes_o,
  output logic       load_o,
  output logic       run_en_o,
  output logic [5:0] blank_mask_o,
  output logic [1:0] mode_o
);

  localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned RepW  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int unsigned BlkW  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [DbW-1:0]   DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES);
  localparam logic [RepW-1:0]  RepLast = RepW'(REPEAT_CYCLES - 1);
  localparam logic [BlkW-1:0]  BlkLast = BlkW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StSetH = 2'd1,
    StSetM = 2'd2,
    StLoad = 2'd3
  } state_e;

  // Index 0 is the mode button, index 1 the increment button.
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     deb_q, deb_d;
  logic [1:0]     press_q, press_d;
  logic [DbW-1:0] db_cnt_q [2];
  logic [DbW-1:0] db_cnt_d [2];

  logic [HoldW-1:0] hold_q, hold_d;
  logic [RepW-1:0]  rep_q, rep_d;
  logic             rpt_q, rpt_d;

  state_e          state_q, state_d;
  logic [5:0]      set_h_q, set_h_d;
  logic [5:0]      set_m_q, set_m_d;
  logic [BlkW-1:0] blink_q, blink_d;
  logic            phase_q, phase_d;
  logic            blink_clr;
  logic [5:0]      mask_q, mask_d;
  logic            load_q, load_d;
  logic            run_en_q, run_en_d;

  logic mode_evt, inc_evt;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i]    = deb_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          deb_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
      press_d[i] = deb_q[i] & ~deb_d[i];
    end
  end

  // Hold counter saturates at HOLD_CYCLES, then the repeat counter paces further events.
  always_comb begin
    hold_d = hold_q;
    rep_d  = rep_q;
    rpt_d  = 1'b0;
    if (deb_q[1]) begin
      hold_d = '0;
      rep_d  = '0;
    end else if (hold_q != HoldMax) begin
      hold_d = hold_q + HoldW'(1);
      rpt_d  = (hold_d == HoldMax);
    end else if (rep_q == RepLast) begin
      rep_d = '0;
      rpt_d = 1'b1;
    end else begin
      rep_d = rep_q + RepW'(1);
    end
  end

  assign mode_evt = press_q[0];
  assign inc_evt  = press_q[1] | rpt_q;

  always_comb begin
    state_d   = state_q;
    set_h_d   = set_h_q;
    set_m_d   = set_m_q;
    blink_clr = 1'b0;
    case (state_q)
      StRun: begin
        if (mode_evt) begin
          state_d = StSetH;
          set_h_d = (cur_hours_i > 6'd23) ? 6'd0 : cur_hours_i;
          set_m_d = (cur_minutes_i > 6'd59) ? 6'd0 : cur_minutes_i;
        end
      end
      StSetH: begin
        if (mode_evt) begin
          state_d = StSetM;
        end else if (inc_evt) begin
          set_h_d   = (set_h_q >= 6'd23) ? 6'd0 : set_h_q + 6'd1;
          blink_clr = 1'b1;
        end
      end
      StSetM: begin
        if (mode_evt) begin
          state_d = StLoad;
        end else if (inc_evt) begin
          set_m_d   = (set_m_q >= 6'd59) ? 6'd0 : set_m_q + 6'd1;
          blink_clr = 1'b1;
        end
      end
      StLoad:  state_d = StRun;
      default: state_d = StRun;
    endcase
    if (state_d != state_q) begin
      blink_clr = 1'b1;
    end
  end

  always_comb begin
    blink_d = blink_q;
    phase_d = phase_q;
    if (blink_clr) begin
      blink_d = '0;
      phase_d = 1'b0;
    end else if (blink_q == BlkLast) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end else begin
      blink_d = blink_q + BlkW'(1);
    end
  end

  // Outputs are derived from next-state values so they register alongside the state.
  always_comb begin
    mask_d   = '0;
    load_d   = (state_d == StLoad);
    run_en_d = (state_d == StRun);
    if (state_d == StSetH) begin
      mask_d[5:4] = {2{phase_d}};
    end else if (state_d == StSetM) begin
      mask_d[3:2] = {2{phase_d}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      deb_q    <= 2'b11;
      press_q  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
      hold_q   <= '0;
      rep_q    <= '0;
      rpt_q    <= 1'b0;
      state_q  <= StRun;
      set_h_q  <= '0;
      set_m_q  <= '0;
      blink_q  <= '0;
      phase_q  <= 1'b0;
      mask_q   <= '0;
      load_q   <= 1'b0;
      run_en_q <= 1'b1;
    end else begin
      sync1_q  <= {btn_inc_n_i, btn_mode_n_i};
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      press_q  <= press_d;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      hold_q   <= hold_d;
      rep_q    <= rep_d;
      rpt_q    <= rpt_d;
      state_q  <= state_d;
      set_h_q  <= set_h_d;
      set_m_q  <= set_m_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
      mask_q   <= mask_d;
      load_q   <= load_d;
      run_en_q <= run_en_d;
    end
  end

  assign set_hours_o   = set_h_q;
  assign set_minutes_o = set_m_q;
  assign load_o        = load_q;
  assign run_en_o      = run_en_q;
  assign blank_mask_o  = mask_q;
  assign mode_o        = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed button stimulus for time_set_ctrl, checked every cycle against a
// behavioural model plus hand-computed literal expectations.
module tb_time_set_ctrl;
  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 5;
  localparam int B = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode_n, btn_inc_n;
  logic [5:0] cur_hours, cur_minutes;
  logic [5:0] set_hours, set_minutes, blank_mask;
  logic       load, run_en;
  logic [1:0] mode;

  int errs = 0;
  int checks = 0;
  int dut_loads = 0;

  time_set_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R),
    .BLINK_CYCLES   (B)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_mode_n_i (btn_mode_n),
    .btn_inc_n_i  (btn_inc_n),
    .cur_hours_i  (cur_hours),
    .cur_minutes_i(cur_minutes),
    .set_hours_o  (set_hours),
    .set_minutes_o(set_minutes),
    .load_o       (load),
    .run_en_o     (run_en),
    .blank_mask_o (blank_mask),
    .mode_o       (mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: state number, edited values, raw sample history, accepted levels,
  // cycles held since press, cycles since last blink restart, events pending for next edge.
  int        m_st, m_sh, m_sm, m_hc, m_since;
  bit [15:0] m_hist [2];
  bit [1:0]  m_acc;
  bit        m_mode_p, m_inc_p;
  bit        s_rst;
  bit [1:0]  s_btn;
  int        s_ch, s_cm;

  task automatic model_reset();
    m_st = 0; m_sh = 0; m_sm = 0; m_hc = 0; m_since = 0;
    m_hist[0] = '1; m_hist[1] = '1; m_acc = 2'b11;
    m_mode_p = 1'b0; m_inc_p = 1'b0;
  endtask

  task automatic model_step();
    int nst;
    bit clr, rpt, v, same;
    bit [1:0] prs;
    nst = m_st;
    clr = 1'b0;
    case (m_st)
      0: if (m_mode_p) begin
        nst  = 1;
        m_sh = (s_ch <= 23) ? s_ch : 0;
        m_sm = (s_cm <= 59) ? s_cm : 0;
      end
      1: if (m_mode_p) nst = 2;
         else if (m_inc_p) begin m_sh = (m_sh + 1) % 24; clr = 1'b1; end
      2: if (m_mode_p) nst = 3;
         else if (m_inc_p) begin m_sm = (m_sm + 1) % 60; clr = 1'b1; end
      default: nst = 0;
    endcase
    if (nst != m_st) clr = 1'b1;
    m_st    = nst;
    m_since = clr ? 0 : m_since + 1;
    rpt = 1'b0;
    if (m_acc[1]) m_hc = 0;
    else begin
      m_hc++;
      rpt = (m_hc == H) || (m_hc > H && (m_hc - H) % R == 0);
    end
    // A level is accepted once D consecutive synchronized samples (2 cycles old) agree.
    prs = 2'b00;
    for (int b = 0; b < 2; b++) begin
      m_hist[b] = {m_hist[b][14:0], s_btn[b]};
      v    = m_hist[b][2];
      same = 1'b1;
      for (int j = 3; j <= D + 1; j++) if (m_hist[b][j] != v) same = 1'b0;
      if (same && v != m_acc[b]) begin
        m_acc[b] = v;
        prs[b]   = ~v;
      end
    end
    m_mode_p = prs[0];
    m_inc_p  = prs[1] | rpt;
  endtask

  function automatic int exp_mask();
    int ph;
    ph = (m_since / B) % 2;
    if (m_st == 1) return ph ? 48 : 0;
    if (m_st == 2) return ph ? 12 : 0;
    return 0;
  endfunction

  always begin
    @(posedge clk);
    s_rst = rst;
    s_btn = {btn_inc_n, btn_mode_n};
    s_ch  = int'(cur_hours);
    s_cm  = int'(cur_minutes);
    @(negedge clk);
    if (!rst) model_reset();
    else if (s_rst) model_step();
    if (load === 1'b1) dut_loads++;
    chk("mode", int'(mode), m_st);
    chk("run_en", int'(run_en), (m_st == 0) ? 1 : 0);
    chk("load", int'(load), (m_st == 3) ? 1 : 0);
    chk("set_hours", int'(set_hours), m_sh);
    chk("set_minutes", int'(set_minutes), m_sm);
    chk("blank_mask", int'(blank_mask), exp_mask());
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit inc, input int hold, input int gap);
    if (inc) btn_inc_n = 1'b0;
    else btn_mode_n = 1'b0;
    tick(hold);
    btn_inc_n  = 1'b1;
    btn_mode_n = 1'b1;
    tick(gap);
  endtask

  initial begin
    int seen, lc, h_at, m_at, ph, pm, prev_h, prev_m, nxt_mode, nxt_run;
    bit after;
    rst = 1'b0; btn_mode_n = 1'b1; btn_inc_n = 1'b1;
    cur_hours = 6'd13; cur_minutes = 6'd45;
    tick(3);
    chk("rst_mode", int'(mode), 0);
    chk("rst_run_en", int'(run_en), 1);
    chk("rst_load", int'(load), 0);
    chk("rst_mask", int'(blank_mask), 0);
    chk("rst_set_h", int'(set_hours), 0);
    chk("rst_set_m", int'(set_minutes), 0);
    rst = 1'b1;
    tick(3);

    press(1'b1, 8, 10);
    chk("run_inc_ignored", int'(mode), 0);

    btn_mode_n = 1'b0; tick(3); btn_mode_n = 1'b1; tick(15);
    chk("glitch_no_event", int'(mode), 0);

    press(1'b0, 10, 12);
    chk("capture_mode", int'(mode), 1);
    chk("capture_h", int'(set_hours), 13);
    chk("capture_m", int'(set_minutes), 45);
    chk("capture_run_en", int'(run_en), 0);

    for (int i = 0; i < 9; i++) press(1'b1, 8, 10);
    chk("h_at_22", int'(set_hours), 22);

    btn_inc_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      tick(1);
      if (set_hours != 6'd22) seen = 1;
    end
    btn_inc_n = 1'b1;
    chk("inc_seen", seen, 1);
    chk("h_23", int'(set_hours), 23);
    chk("blink_visible_after_inc", int'(blank_mask[5:4]), 0);
    tick(8);
    chk("blink_blank_8", int'(blank_mask[5:4]), 3);
    tick(8);
    chk("blink_visible_16", int'(blank_mask[5:4]), 0);
    tick(6);
    press(1'b1, 8, 10);
    chk("h_wrap_0", int'(set_hours), 0);

    press(1'b0, 10, 12);
    chk("set_m_mode", int'(mode), 2);
    for (int i = 0; i < 13; i++) press(1'b1, 8, 10);
    chk("m_at_58", int'(set_minutes), 58);

    press(1'b1, 38, 15);
    chk("repeat_m_3", int'(set_minutes), 3);
    chk("repeat_h_kept", int'(set_hours), 0);

    lc = 0; after = 1'b0; h_at = -1; m_at = -1; prev_h = -1; prev_m = -1;
    nxt_mode = -1; nxt_run = -1;
    btn_mode_n = 1'b0;
    for (int i = 0; i < 30; i++) begin
      ph = int'(set_hours);
      pm = int'(set_minutes);
      tick(1);
      if (i == 9) btn_mode_n = 1'b1;
      if (after) begin nxt_mode = int'(mode); nxt_run = int'(run_en); after = 1'b0; end
      if (load) begin
        lc++; h_at = int'(set_hours); m_at = int'(set_minutes);
        prev_h = ph; prev_m = pm; after = 1'b1;
      end
    end
    chk("load_cycles", lc, 1);
    chk("load_h", h_at, 0);
    chk("load_m", m_at, 3);
    chk("pre_load_h", prev_h, 0);
    chk("pre_load_m", prev_m, 3);
    chk("post_load_mode", nxt_mode, 0);
    chk("post_load_run_en", nxt_run, 1);
    chk("hold_after_load_m", int'(set_minutes), 3);

    cur_hours = 6'd30; cur_minutes = 6'd61;
    press(1'b0, 10, 12);
    chk("oor_mode", int'(mode), 1);
    chk("oor_h", int'(set_hours), 0);
    chk("oor_m", int'(set_minutes), 0);

    btn_mode_n = 1'b0; btn_inc_n = 1'b0;
    tick(8);
    btn_mode_n = 1'b1; btn_inc_n = 1'b1;
    tick(12);
    chk("simul_mode", int'(mode), 2);
    chk("simul_h_unchanged", int'(set_hours), 0);

    rst = 1'b0;
    #2;
    chk("midreset_mode", int'(mode), 0);
    chk("midreset_run_en", int'(run_en), 1);
    chk("midreset_load", int'(load), 0);
    tick(2);
    rst = 1'b1;
    tick(5);
    chk("after_reset_mode", int'(mode), 0);
    chk("total_loads", dut_loads, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Button-driven controller that sequences the time-of-day counter between run and set modes. Debounces two raw push-buttons, steps through hour and minute editing, and produces a one-cycle load strobe with the edited hours and minutes. Also supplies the counter enable and a per-digit blanking mask so the display multiplexer blinks the field being edited. Sits between the board buttons and the timer/display datapath.

## Interface

- DEBOUNCE_CYCLES, 500000: cycles a synchronized button level must be stable before it is accepted (10 ms at 50 MHz)
- HOLD_CYCLES, 50000000: cycles inc must be held before auto-repeat starts
- REPEAT_CYCLES, 10000000: auto-repeat period while inc stays held
- BLINK_CYCLES, 12500000: half-period of the edit-field blink
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- btn_mode_n  in  1  raw mode button, active-low, asynchronous to clk
- btn_inc_n  in  1  raw increment button, active-low, asynchronous to clk
- cur_hours  in  6  live hours from the counter, 0..23
- cur_minutes  in  6  live minutes from the counter, 0..59
- set_hours  out  6  edited hours, valid while load=1
- set_minutes  out  6  edited minutes, valid while load=1
- load  out  1  one-cycle strobe; counter takes set_* and clears seconds
- run_en  out  1  counter enable; high only in RUN
- blank_mask  out  6  1 = blank digit; bits [1:0] seconds, [3:2] minutes, [5:4] hours (bit 0 = units)
- mode  out  2  current state encoding: 0 RUN, 1 SET_H, 2 SET_M, 3 LOAD

## Operation

- Each button goes through a 2-flop synchronizer, then a debounce counter. The counter resets on any change of the synchronized level. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronized value.
- A press event is a single-cycle pulse on the debounced transition released→pressed. A release produces no event.
- Auto-repeat (inc only, in SET_H/SET_M):
  - After a press event, a hold counter runs while inc stays pressed.
  - When it reaches HOLD_CYCLES, one inc event fires; after that, one fires every REPEAT_CYCLES.
  - Release clears the hold counter. Mode has no auto-repeat.
- FSM:
  - RUN: run_en=1, blank_mask=0. A mode event captures set_hours←cur_hours and set_minutes←cur_minutes, then goes to SET_H. A captured value out of range (hours>23, minutes>59) is replaced by 0. Inc events are ignored.
  - SET_H: run_en=0. An inc event does set_hours+1, wrapping 23→0. A mode event goes to SET_M.
  - SET_M: run_en=0. An inc event does set_minutes+1, wrapping 59→0. A mode event goes to LOAD.
  - LOAD: load=1 for exactly this one cycle, run_en=0, then unconditionally RUN.
- Simultaneous mode and inc events in one cycle: mode wins and the inc is discarded.
- Blink:
  - A counter wraps at BLINK_CYCLES-1 and toggles a phase bit.
  - In SET_H, blank_mask[5:4] = {phase,phase}. In SET_M, blank_mask[3:2] = {phase,phase}. All other bits are 0.
  - Every inc event and every state entry clears the counter and sets phase=0 (visible), so edits show immediately.
- set_* hold their value after LOAD until the next capture.
- Arithmetic is 6-bit unsigned. Increments are compare-then-wrap, never modulo of an overflowed value.

## Timing

- Reset values:
  - Outputs: state RUN, mode=0, run_en=1, load=0, set_hours=0, set_minutes=0, blank_mask=0.
  - Internal: synchronizers and debounced levels at released (1), all counters 0, phase 0.
- Reset asserted mid-edit returns to RUN with no load pulse. The counter resumes from its own value.
- Button latency: 2 synchronizer cycles + DEBOUNCE_CYCLES stable cycles + 1 cycle to the event pulse. The state/register update happens on the edge after the event.
- Glitches shorter than DEBOUNCE_CYCLES produce no event.
- load is asserted in the cycle after the mode event that leaves SET_M. run_en rises the following cycle. set_* are stable from at least one cycle before load through load.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan

Run with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5, BLINK_CYCLES=8.

- Reset with buttons released → mode=0, run_en=1, load=0, blank_mask=0, set_*=0.
- cur=13:45; mode press held 10 cycles → mode=1, set_hours=13, set_minutes=45, run_en=0. A 3-cycle mode glitch before that → no state change.
- In SET_H with set_hours=22, two inc presses → 23 then 0. blank_mask[5:4] toggles every 8 cycles and reads 00 right after each inc.
- In SET_M with set_minutes=58, inc held 35 cycles past debounce → press event plus repeats at hold 20, 25, 30, 35. Minutes 58→59→0→1→2→3 (4 repeats + 1 press = 5 increments, wrapping 59→0).
- SET_M, mode press → exactly one cycle of load=1 with set_hours=0, set_minutes=3. Next cycle mode=0, run_en=1.
- Mode and inc debounced in the same cycle in SET_H → advance to SET_M, set_hours unchanged. rst low during SET_M → immediate RUN, load never pulses.
